// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-port word memory that answers one processor request at a time after a
// programmable number of wait cycles.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  wait cycles between request capture and response (0..15)
//
// Ports
//   clk        clock, all state changes on its rising edge
//   reset      synchronous, active-low reset
//   MemReq     request strobe, held high by the requester until MemReady
//   MemWrite   1 = write, 0 = read (captured with MemReq)
//   Adr        byte address; word index is Adr[log2(DEPTH)+1:2]
//   WriteData  store data (captured with MemReq)
//   ReadData   read result, valid while MemReady is high after a read,
//              held until the next read completes
//   MemReady   one-cycle completion pulse
//   MemErr     error qualifier, only ever high together with MemReady
//
// Build option
//   MEM_RESPONDER_ALIGN_CHECK_EN  when defined, requests with Adr[1:0] != 0
//   complete with normal timing, write nothing, return 0 for reads and raise
//   MemErr. When undefined, Adr[1:0] is ignored and MemErr is always 0.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          misaligned;

  // Upper address bits make the index wrap modulo DEPTH words.
  assign idx = adr_q[AW+1:2];

  logic unused_adr_hi;
  assign unused_adr_hi = ^adr_q[31:AW+2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned = (adr_q[1:0] != 2'b00);
`else
  logic unused_adr_lo;
  assign unused_adr_lo = ^adr_q[1:0];
  assign misaligned    = 1'b0;
`endif

  // Control FSM. The operation is carried out on the clock edge that closes
  // the RESP state, so the registered MemReady/ReadData appear LATENCY+1
  // cycles after the capture edge, and a still-asserted MemReq is captured
  // again on the very next edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      adr_q   <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemReq) begin
            write_q <= MemWrite;
            adr_q   <= Adr;
            wdata_q <= WriteData;
            cnt_q   <= 4'(LATENCY);
            state_q <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          err_q   <= misaligned;
          if (!write_q) begin
            rdata_q <= misaligned ? 32'd0 : mem_q[idx];
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory array is never reset. A write whose RESP state was reached before
  // a reset edge still commits, because this path does not look at reset.
  always_ff @(posedge clk) begin
    if (state_q == RESP && write_q && !misaligned) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main instance, LATENCY = 2
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, err;

  // second instance, LATENCY = 0
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] adr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0, err0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .MemReq(req), .MemWrite(we), .Adr(adr),
    .WriteData(wdata), .ReadData(rdata), .MemReady(ready), .MemErr(err)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(we0), .Adr(adr0),
    .WriteData(wdata0), .ReadData(rdata0), .MemReady(ready0), .MemErr(err0)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: word array plus the last read value
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd = 32'd0;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vec [11];
  vec_t ops [6];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit misal(input logic [31:0] a);
    logic [31:0] t;
    t = a;
    return ALIGN && (t[1:0] != 2'b00);
  endfunction

  // Applies one operation to the model; returns expected read value and error.
  task automatic model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] exp_rd, output bit exp_err);
    exp_err = misal(a);
    if (w) begin
      if (!exp_err) model_mem[widx(a)] = d;
    end else begin
      model_rd = exp_err ? 32'd0 : model_mem[widx(a)];
    end
    exp_rd = model_rd;
  endtask

  // Drives one request on the main instance and waits (bounded) for MemReady.
  // lat = number of rising edges from request assertion to MemReady visible.
  task automatic apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit perturb, output logic [31:0] rd, output logic e,
                       output int lat);
    rd = 32'd0; e = 1'b0; lat = 0;
    we = w; adr = a; wdata = d; req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (perturb && k == 1) begin
        adr = 32'h24; wdata = 32'hBAD0BAD0; we = ~w;
      end
      if (ready) begin
        lat = k; rd = rdata; e = err;
        break;
      end
    end
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_txn(input string name, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit perturb);
    logic [31:0] rd, exp_rd;
    logic        e;
    bit          exp_err;
    int          lat;
    apply(w, a, d, perturb, rd, e, lat);
    model_apply(w, a, d, exp_rd, exp_err);
    check32({name, "_latency"}, 32'(lat), 32'(LAT + 2));
    check32({name, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check32({name, "_rdata"}, rd, exp_rd);
    $display("txn %s w=%0d adr=0x%08h wd=0x%08h rd=0x%08h err=%0d lat=%0d",
             name, w, a, d, rd, e, lat);
  endtask

  // MemErr must never be high without MemReady
  always @(negedge clk) begin
    if (reset && !ready) check32("err_without_ready", {31'd0, err}, 32'd0);
    if (reset && !ready0) check32("err0_without_ready", {31'd0, err0}, 32'd0);
  end

  initial begin
    logic [31:0] rd, dummy;
    logic        e;
    int          lat;
    bit          seen;
    bit          dummy_err;

    vec[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vec[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vec[2]  = '{1'b1, 32'h0000_0104, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vec[3]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0};
    vec[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vec[5]  = '{1'b0, 32'hFFFF_FF10, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vec[6]  = '{1'b1, 32'h0000_0040, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0};
    vec[7]  = '{1'b1, 32'h0000_0042, 32'hCAFE_F00D, 32'hDEAD_BEEF, ALIGN};
    vec[8]  = '{1'b0, 32'h0000_0040, 32'h0,
                ALIGN ? 32'h0BAD_F00D : 32'hCAFE_F00D, 1'b0};
    vec[9]  = '{1'b0, 32'h0000_0043, 32'h0,
                ALIGN ? 32'h0000_0000 : 32'hCAFE_F00D, ALIGN};
    vec[10] = '{1'b1, 32'h0000_0030, 32'h0000_0000,
                ALIGN ? 32'h0000_0000 : 32'hCAFE_F00D, 1'b0};

    ops[0] = '{1'b1, 32'h00, 32'h1111_1111, 32'h0, 1'b0};
    ops[1] = '{1'b1, 32'h04, 32'h2222_2222, 32'h0, 1'b0};
    ops[2] = '{1'b0, 32'h00, 32'h0, 32'h1111_1111, 1'b0};
    ops[3] = '{1'b0, 32'h04, 32'h0, 32'h2222_2222, 1'b0};
    ops[4] = '{1'b0, 32'h00, 32'h0, 32'h1111_1111, 1'b0};
    ops[5] = '{1'b0, 32'h04, 32'h0, 32'h2222_2222, 1'b0};

    // reset
    repeat (3) @(posedge clk);
    #1;
    check32("reset_rdata", rdata, 32'd0);
    check32("reset_ready", {31'd0, ready}, 32'd0);
    check32("reset_err", {31'd0, err}, 32'd0);
    check32("reset_rdata0", rdata0, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // preload every word so the model is fully known
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      apply(1'b1, 32'(i * 4), v, 1'b0, rd, e, lat);
      model_apply(1'b1, 32'(i * 4), v, dummy, dummy_err);
      check32("preload_latency", 32'(lat), 32'(LAT + 2));
    end

    // directed table
    for (int i = 0; i < 11; i++) begin
      apply(vec[i].w, vec[i].a, vec[i].d, 1'b0, rd, e, lat);
      model_apply(vec[i].w, vec[i].a, vec[i].d, dummy, dummy_err);
      check32($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT + 2));
      check32($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vec[i].exp_err});
      check32($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rd);
      $display("vec %0d w=%0d adr=0x%08h rd=0x%08h err=%0d lat=%0d",
               i, vec[i].w, vec[i].a, rd, e, lat);
    end

    // inputs changed after capture must not affect the write
    do_txn("perturb_wr20", 1'b1, 32'h20, 32'h600D_CAFE, 1'b1);
    do_txn("perturb_rd20", 1'b0, 32'h20, 32'h0, 1'b0);
    do_txn("perturb_rd24", 1'b0, 32'h24, 32'h0, 1'b0);

    // reset in the middle of WAIT aborts a write
    we = 1'b1; adr = 32'h30; wdata = 32'h55AA_55AA; req = 1'b1;
    @(posedge clk); #1;            // captured
    @(posedge clk); #1;            // in WAIT
    reset = 1'b0; req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ready) seen = 1'b1;
      @(posedge clk); #1;
    end
    check32("abort_no_ready", {31'd0, seen}, 32'd0);
    check32("abort_rdata_zero", rdata, 32'd0);
    model_rd = 32'd0;
    $display("abort sequence ready_seen=%0d rdata=0x%08h", seen, rdata);
    do_txn("abort_rd30", 1'b0, 32'h30, 32'h0, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, d;
      bit w;
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      do_txn($sformatf("rnd%0d", i), w, a, d, 1'b0);
    end

    // LATENCY = 0, MemReq held high: a response every second cycle
    we0 = ops[0].w; adr0 = ops[0].a; wdata0 = ops[0].d; req0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      check32($sformatf("lat0_ready_edge%0d", i), {31'd0, ready0}, {31'd0, (i % 2) == 0});
      if (ready0 && (i % 2) == 0) begin
        int j;
        j = i / 2 - 1;
        if (!ops[j].w) check32($sformatf("lat0_rdata_op%0d", j), rdata0, ops[j].exp_rd);
        $display("lat0 op %0d w=%0d adr=0x%08h rd=0x%08h", j, ops[j].w, ops[j].a, rdata0);
        if (j + 1 < 6) begin
          we0 = ops[j+1].w; adr0 = ops[j+1].a; wdata0 = ops[j+1].d;
        end else begin
          req0 = 1'b0;
        end
      end
    end
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
